// File: rtl/polyphase_tap_sequencer.sv
// Polyphase tap sequencer: streams NUM_TAPS sample/coefficient pairs per input sample into one MAC slice.
// Define POLYPHASE_TAP_SEQUENCER_PERF_COUNT_EN to add the perf_sample_count / perf_stall_count outputs.
//
// state    | meaning
// ST_IDLE  | waiting for a sample; coefficient writes accepted; MAC B register held clear
// ST_RUN   | presenting tap k: x[(wp-k) mod NUM_TAPS] with h[k], NUM_TAPS cycles
// ST_DRAIN | MAC pipeline draining, MAC_LATENCY cycles; result captured on the last one
module polyphase_tap_sequencer #(
   parameter int DATA_WIDTH        = 16,
   parameter int COEFFICIENT_WIDTH = 16,
   parameter int NUM_TAPS          = 8,
   parameter int MAC_LATENCY       = 3,
   parameter int ADDR_WIDTH        = $clog2(NUM_TAPS)
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic [DATA_WIDTH-1:0]        s_data,
   input  logic                         s_valid,
   output logic                         s_ready,
   input  logic                         coef_wr_en,
   input  logic [ADDR_WIDTH-1:0]        coef_wr_addr,
   input  logic [COEFFICIENT_WIDTH-1:0] coef_wr_data,
   output logic                         coef_wr_ready,
   output logic [DATA_WIDTH-1:0]        mac_data_in,
   output logic [COEFFICIENT_WIDTH-1:0] mac_coefficient,
   output logic                         mac_ce_calculate,
   output logic                         mac_ce_coefficient,
   output logic                         mac_reset_coefficient,
   output logic [6:0]                   mac_op_mode,
   output logic [4:0]                   mac_in_mode,
   input  logic [DATA_WIDTH-1:0]        mac_data_out,
   output logic [DATA_WIDTH-1:0]        m_data,
   output logic                         m_valid,
`ifdef POLYPHASE_TAP_SEQUENCER_PERF_COUNT_EN
   output logic [31:0]                  perf_sample_count,
   output logic [31:0]                  perf_stall_count,
`endif
   input  logic                         m_ready
);

   localparam logic [6:0] OP_LOAD = 7'b0000101;
   localparam logic [6:0] OP_ACC  = 7'b0100101;
   localparam int DRAIN_W = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;
   localparam logic [DRAIN_W-1:0]    DRAIN_LOAD = DRAIN_W'(MAC_LATENCY - 1);
   localparam logic [ADDR_WIDTH-1:0] TAP_LAST   = ADDR_WIDTH'(NUM_TAPS - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   wp_q, wp_d;
   logic [ADDR_WIDTH-1:0]   tap_q, tap_d;
   logic [DRAIN_W-1:0]      drain_q, drain_d;
   logic                    m_valid_q, m_valid_d;
   logic [DATA_WIDTH-1:0]   m_data_q, m_data_d;
   logic [6:0]              op_mode_q, op_mode_d;

   logic [DATA_WIDTH-1:0]        dline_q    [NUM_TAPS];
   logic [COEFFICIENT_WIDTH-1:0] coef_mem_q [NUM_TAPS];

   logic                  accept;
   logic                  coef_we;
   logic [ADDR_WIDTH-1:0] rd_addr;

   // Modular subtraction gives the circular delay-line wrap for free.
   assign rd_addr = wp_q - tap_q;

   assign coef_wr_ready = (state_q == ST_IDLE);
   assign coef_we       = coef_wr_en && coef_wr_ready;
   assign mac_in_mode   = 5'b00000;
   assign mac_op_mode   = op_mode_q;
   assign m_data        = m_data_q;
   assign m_valid       = m_valid_q;

   always_comb begin
      state_d               = state_q;
      wp_d                  = wp_q;
      tap_d                 = tap_q;
      drain_d               = drain_q;
      m_valid_d             = m_valid_q;
      m_data_d              = m_data_q;
      op_mode_d             = OP_ACC;
      accept                = 1'b0;
      s_ready               = 1'b0;
      mac_ce_calculate      = 1'b0;
      mac_ce_coefficient    = 1'b0;
      mac_reset_coefficient = 1'b0;
      mac_data_in           = '0;
      mac_coefficient       = '0;

      if (m_valid_q && m_ready) begin
         m_valid_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            s_ready               = !m_valid_q || m_ready;
            mac_reset_coefficient = 1'b1;
            if (s_valid && s_ready) begin
               accept  = 1'b1;
               tap_d   = '0;
               state_d = ST_RUN;
            end
         end

         ST_RUN: begin
            mac_ce_calculate   = 1'b1;
            mac_ce_coefficient = 1'b1;
            mac_data_in        = dline_q[rd_addr];
            mac_coefficient    = coef_mem_q[tap_q];
            // op_mode reaches the MAC one cycle behind its data to meet OPMODEREG.
            if (tap_q == '0) begin
               op_mode_d = OP_LOAD;
            end
            if (tap_q == TAP_LAST) begin
               drain_d = DRAIN_LOAD;
               state_d = ST_DRAIN;
            end else begin
               tap_d = tap_q + ADDR_WIDTH'(1);
            end
         end

         ST_DRAIN: begin
            mac_ce_calculate = 1'b1;
            if (drain_q == '0) begin
               m_data_d  = mac_data_out;
               m_valid_d = 1'b1;
               wp_d      = wp_q + ADDR_WIDTH'(1);
               state_d   = ST_IDLE;
            end else begin
               drain_d = drain_q - DRAIN_W'(1);
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         wp_q      <= '0;
         tap_q     <= '0;
         drain_q   <= '0;
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
         op_mode_q <= '0;
      end else begin
         state_q   <= state_d;
         wp_q      <= wp_d;
         tap_q     <= tap_d;
         drain_q   <= drain_d;
         m_valid_q <= m_valid_d;
         m_data_q  <= m_data_d;
         op_mode_q <= op_mode_d;
      end
   end

   // Storage arrays carry no reset; stale history is overwritten as samples arrive.
   always_ff @(posedge clock) begin
      if (accept) begin
         dline_q[wp_q] <= s_data;
      end
      if (coef_we) begin
         coef_mem_q[coef_wr_addr] <= coef_wr_data;
      end
   end

`ifdef POLYPHASE_TAP_SEQUENCER_PERF_COUNT_EN
   logic [31:0] perf_sample_q, perf_sample_d;
   logic [31:0] perf_stall_q, perf_stall_d;

   always_comb begin
      perf_sample_d = perf_sample_q;
      perf_stall_d  = perf_stall_q;
      if (m_valid_q && m_ready) begin
         perf_sample_d = perf_sample_q + 32'd1;
      end
      if (m_valid_q && !m_ready) begin
         perf_stall_d = perf_stall_q + 32'd1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         perf_sample_q <= '0;
         perf_stall_q  <= '0;
      end else begin
         perf_sample_q <= perf_sample_d;
         perf_stall_q  <= perf_stall_d;
      end
   end

   assign perf_sample_count = perf_sample_q;
   assign perf_stall_count  = perf_stall_q;
`endif

endmodule

// File: tb/tb_polyphase_tap_sequencer.sv
// Directed bench for polyphase_tap_sequencer (NUM_TAPS=4) driving a behavioural DSP-style MAC model.
`timescale 1ns/1ps
module tb_polyphase_tap_sequencer;
   localparam int DW = 16;
   localparam int CW = 16;
   localparam int NT = 4;
   localparam int ML = 3;
   localparam int AW = 2;
   localparam int RUN_LAT = NT + ML + 1;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic [DW-1:0] s_data;
   logic          s_valid;
   logic          s_ready;
   logic          coef_wr_en;
   logic [AW-1:0] coef_wr_addr;
   logic [CW-1:0] coef_wr_data;
   logic          coef_wr_ready;
   logic [DW-1:0] mac_data_in;
   logic [CW-1:0] mac_coefficient;
   logic          mac_ce_calculate;
   logic          mac_ce_coefficient;
   logic          mac_reset_coefficient;
   logic [6:0]    mac_op_mode;
   logic [4:0]    mac_in_mode;
   logic [DW-1:0] mac_data_out;
   logic [DW-1:0] m_data;
   logic          m_valid;
   logic          m_ready;

   int n_eval = 0;
   int n_fail = 0;

   logic [15:0] ramp_exp [10] = '{16'd0, 16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};

   always #5 clock = ~clock;

   polyphase_tap_sequencer #(
      .DATA_WIDTH(DW), .COEFFICIENT_WIDTH(CW), .NUM_TAPS(NT), .MAC_LATENCY(ML), .ADDR_WIDTH(AW)
   ) dut (
      .clock(clock), .reset(reset),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .coef_wr_en(coef_wr_en), .coef_wr_addr(coef_wr_addr), .coef_wr_data(coef_wr_data),
      .coef_wr_ready(coef_wr_ready),
      .mac_data_in(mac_data_in), .mac_coefficient(mac_coefficient),
      .mac_ce_calculate(mac_ce_calculate), .mac_ce_coefficient(mac_ce_coefficient),
      .mac_reset_coefficient(mac_reset_coefficient), .mac_op_mode(mac_op_mode),
      .mac_in_mode(mac_in_mode), .mac_data_out(mac_data_out),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready)
   );

   // MAC model: AREG/BREG, MREG, PREG and OPMODEREG, result taken from P[31:16].
   logic signed [15:0] a_q, b_q;
   logic signed [47:0] mm_q, p_q;
   logic [6:0]         op_q;

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         a_q <= '0; b_q <= '0; mm_q <= '0; p_q <= '0; op_q <= '0;
      end else begin
         if (mac_reset_coefficient) b_q <= '0;
         else if (mac_ce_coefficient) b_q <= mac_coefficient;
         if (mac_ce_calculate) begin
            a_q  <= mac_data_in;
            mm_q <= 48'(a_q) * 48'(b_q);
            op_q <= mac_op_mode;
            p_q  <= (op_q == 7'b0000101) ? mm_q : p_q + mm_q;
         end
      end
   end
   assign mac_data_out = p_q[31:16];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_eval++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wr_coef(input logic [AW-1:0] addr, input logic [CW-1:0] data);
      coef_wr_en = 1'b1; coef_wr_addr = addr; coef_wr_data = data;
      @(posedge clock); #1;
      coef_wr_en = 1'b0;
   endtask

   // Entered and left just after a rising edge.
   task automatic run_sample(input logic [15:0] din, input logic [15:0] exp, input string tag,
                             input bit poke, input bit stall, input logic [15:0] nxt);
      int n;
      int op0;
      bit got;
      s_data = din; s_valid = 1'b1;
      n = 0;
      while (n < 100) begin
         @(negedge clock);
         if (s_ready) break;
         n++;
         @(posedge clock); #1;
      end
      chk({tag, " accept"}, 32'(n < 100), 32'd1);
      @(posedge clock); #1;
      s_valid = 1'b0;
      n = 0; op0 = 0; got = 1'b0;
      while (!got && n < 40) begin
         @(negedge clock);
         n++;
         coef_wr_en = poke && (n == 1);
         if (poke && n == 1) begin
            coef_wr_addr = '0; coef_wr_data = 16'h7FFF;
            chk({tag, " coef_wr_ready in run"}, 32'(coef_wr_ready), 32'd0);
         end
         if (mac_ce_calculate && mac_op_mode === 7'b0000101) op0++;
         if (m_valid) got = 1'b1;
      end
      coef_wr_en = 1'b0;
      chk({tag, " latency"}, 32'(n), 32'(RUN_LAT));
      chk({tag, " tap0 op_mode count"}, 32'(op0), 32'd1);
      chk({tag, " m_data"}, 32'(m_data), 32'(exp));
      if (!stall) begin
         chk({tag, " s_ready reasserted"}, 32'(s_ready), 32'd1);
      end else begin
         s_valid = 1'b1; s_data = nxt;
         for (int i = 0; i < 20; i++) begin
            @(posedge clock); @(negedge clock);
            chk({tag, " stall m_valid"}, 32'(m_valid), 32'd1);
            chk({tag, " stall m_data"}, 32'(m_data), 32'(exp));
            chk({tag, " stall s_ready"}, 32'(s_ready), 32'd0);
            chk({tag, " stall ce"}, 32'(mac_ce_calculate), 32'd0);
         end
      end
      @(posedge clock); #1;
      if (stall) m_ready = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      s_valid = 1'b0; s_data = '0; coef_wr_en = 1'b0; coef_wr_addr = '0; coef_wr_data = '0;
      m_ready = 1'b1;
      reset = 1'b1;
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("reset m_valid", 32'(m_valid), 32'd0);
      chk("reset m_data", 32'(m_data), 32'd0);
      chk("reset s_ready", 32'(s_ready), 32'd1);
      chk("reset ce_calc", 32'(mac_ce_calculate), 32'd0);
      chk("reset ce_coef", 32'(mac_ce_coefficient), 32'd0);
      chk("reset reset_coef", 32'(mac_reset_coefficient), 32'd1);
      chk("reset op_mode", 32'(mac_op_mode), 32'd0);
      chk("reset in_mode", 32'(mac_in_mode), 32'd0);
      chk("reset coef_wr_ready", 32'(coef_wr_ready), 32'd1);
      @(posedge clock); #1;
      reset = 1'b0;

      // Flush the delay line with zero coefficients so history is known.
      for (int i = 0; i < NT; i++) wr_coef(AW'(i), 16'h0000);
      for (int i = 0; i < NT; i++) run_sample(16'h0000, 16'h0000, "zfill", 1'b0, 1'b0, 16'h0000);

      wr_coef(2'd0, 16'h4000);
      wr_coef(2'd1, 16'h2000);
      wr_coef(2'd2, 16'h1000);
      wr_coef(2'd3, 16'h0800);
      run_sample(16'h7FFF, 16'h1FFF, "imp0", 1'b0, 1'b0, 16'h0000);
      run_sample(16'h0000, 16'h0FFF, "imp1", 1'b1, 1'b0, 16'h0000);
      run_sample(16'h0000, 16'h07FF, "imp2", 1'b0, 1'b0, 16'h0000);
      run_sample(16'h0000, 16'h03FF, "imp3", 1'b0, 1'b0, 16'h0000);

      for (int i = 0; i < NT; i++) wr_coef(AW'(i), 16'h4000);
      for (int i = 1; i <= 10; i++) begin
         if (i == 5) m_ready = 1'b0;
         run_sample(16'(i), ramp_exp[i-1], "ramp", 1'b0, i == 5, 16'(i + 1));
      end

      // Abort a run at tap 2; delay line now holds idx0=9, idx1=10, idx2=7, idx3=8 with wp=2.
      s_data = 16'h0040; s_valid = 1'b1;
      @(negedge clock);
      chk("abort accept", 32'(s_ready), 32'd1);
      @(posedge clock); #1;
      s_valid = 1'b0;
      repeat (3) @(negedge clock);
      chk("abort tap2 data", 32'(mac_data_in), 32'd9);
      chk("abort tap2 coef", 32'(mac_coefficient), 32'h4000);
      reset = 1'b1;
      #1;
      chk("abort m_valid", 32'(m_valid), 32'd0);
      chk("abort m_data", 32'(m_data), 32'd0);
      chk("abort ce_calc", 32'(mac_ce_calculate), 32'd0);
      chk("abort ce_coef", 32'(mac_ce_coefficient), 32'd0);
      chk("abort reset_coef", 32'(mac_reset_coefficient), 32'd1);
      chk("abort op_mode", 32'(mac_op_mode), 32'd0);
      chk("abort data_in", 32'(mac_data_in), 32'd0);
      chk("abort s_ready", 32'(s_ready), 32'd1);
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      seen = 1'b0;
      repeat (15) begin
         @(negedge clock);
         if (m_valid) seen = 1'b1;
      end
      chk("abort no output", 32'(seen), 32'd0);
      @(posedge clock); #1;
      // With wp back at 0: 0x100 + 10 + 0x40 + 8 = 338, times 0x4000 >> 16 = 84.
      run_sample(16'h0100, 16'h0054, "post_reset", 1'b0, 1'b0, 16'h0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
      $finish;
   end
endmodule
